seg7_bus_reader: RTL and testbench



---
 rtl/seg7_bus_reader.sv | 188 ++++++++++++++++++
 tb/tb_seg7_bus_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_bus_reader.sv
// Readback monitor for a multiplexed active-low 4-digit 7-segment bus.
// Each digit pattern must be seen unchanged for STABLE_CYCLES samples before its slot is written.
module seg7_bus_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_n,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     err,
  output logic                      upd,
  output logic [1:0]                upd_idx
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Returns {illegal, blank, nibble} for an active-low g..a pattern.
  function automatic logic [5:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'h40:   seg_decode = {2'b00, 4'h0};
      7'h79:   seg_decode = {2'b00, 4'h1};
      7'h24:   seg_decode = {2'b00, 4'h2};
      7'h30:   seg_decode = {2'b00, 4'h3};
      7'h19:   seg_decode = {2'b00, 4'h4};
      7'h12:   seg_decode = {2'b00, 4'h5};
      7'h02:   seg_decode = {2'b00, 4'h6};
      7'h78:   seg_decode = {2'b00, 4'h7};
      7'h00:   seg_decode = {2'b00, 4'h8};
      7'h10:   seg_decode = {2'b00, 4'h9};
      7'h08:   seg_decode = {2'b00, 4'hA};
      7'h03:   seg_decode = {2'b00, 4'hB};
      7'h46:   seg_decode = {2'b00, 4'hC};
      7'h21:   seg_decode = {2'b00, 4'hD};
      7'h06:   seg_decode = {2'b00, 4'hE};
      7'h0E:   seg_decode = {2'b00, 4'hF};
      7'h7F:   seg_decode = {2'b01, 4'h0};
      default: seg_decode = {2'b10, 4'h0};
    endcase
  endfunction

  logic [6:0]            seg_s_r;
  logic [NUM_DIGITS-1:0] dig_s_r;
  state_t                state_r, state_nxt;
  logic [1:0]            cand_idx_r, cand_idx_nxt;
  logic [6:0]            cand_pat_r, cand_pat_nxt;
  logic [7:0]            cnt_r, cnt_nxt;
  logic                  sel_valid_s;
  logic [1:0]            sel_idx_s;
  logic                  same_s;
  logic [5:0]            dec_s;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [NUM_DIGITS-1:0] blank_r;
  logic [NUM_DIGITS-1:0] err_r;
  logic                  upd_r;
  logic [1:0]            upd_idx_r;

  // Input sample stage; reset value is an invalid (no digit) select.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s_r <= 7'h7F;
      dig_s_r <= 4'hF;
    end else begin
      seg_s_r <= seg_n;
      dig_s_r <= dig_n;
    end
  end

  // One-hot-low select decode; anything else is invalid.
  always_comb begin
    sel_valid_s = 1'b1;
    sel_idx_s   = 2'd0;
    case (dig_s_r)
      4'b1110: sel_idx_s = 2'd0;
      4'b1101: sel_idx_s = 2'd1;
      4'b1011: sel_idx_s = 2'd2;
      4'b0111: sel_idx_s = 2'd3;
      default: sel_valid_s = 1'b0;
    endcase
  end

  assign same_s = sel_valid_s && (sel_idx_s == cand_idx_r) && (seg_s_r == cand_pat_r);
  assign dec_s  = seg_decode(cand_pat_r);

  // Qualifier state, candidate and stability count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cand_idx_r <= 2'd0;
      cand_pat_r <= 7'h00;
      cnt_r      <= 8'd0;
    end else begin
      state_r    <= state_nxt;
      cand_idx_r <= cand_idx_nxt;
      cand_pat_r <= cand_pat_nxt;
      cnt_r      <= cnt_nxt;
    end
  end

  // Next-state logic; a new sample reloads the candidate with count 1.
  always_comb begin
    state_nxt    = state_r;
    cand_idx_nxt = cand_idx_r;
    cand_pat_nxt = cand_pat_r;
    cnt_nxt      = cnt_r;
    case (state_r)
      ST_IDLE, ST_LOCKED: begin
        if ((state_r == ST_LOCKED) && same_s) begin
          state_nxt = ST_LOCKED;
        end else if (sel_valid_s) begin
          state_nxt    = ST_TRACK;
          cand_idx_nxt = sel_idx_s;
          cand_pat_nxt = seg_s_r;
          cnt_nxt      = 8'd1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (!sel_valid_s) begin
          state_nxt = ST_IDLE;
        end else if (!same_s) begin
          state_nxt    = ST_TRACK;
          cand_idx_nxt = sel_idx_s;
          cand_pat_nxt = seg_s_r;
          cnt_nxt      = 8'd1;
        end else begin
          cnt_nxt = (cnt_r >= STABLE_W) ? STABLE_W : (cnt_r + 8'd1);
          if (cnt_r >= (STABLE_W - 8'd1)) begin
            state_nxt = ST_COMMIT;
          end else begin
            state_nxt = ST_TRACK;
          end
        end
      end
      ST_COMMIT: state_nxt = ST_LOCKED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Slot write on commit; only the candidate's slot changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r   <= '0;
      blank_r   <= '1;
      err_r     <= '0;
      upd_r     <= 1'b0;
      upd_idx_r <= 2'd0;
    end else begin
      upd_r <= 1'b0;
      if (state_r == ST_COMMIT) begin
        upd_r     <= 1'b1;
        upd_idx_r <= cand_idx_r;
        case (dec_s[5:4])
          2'b00: begin
            value_r[{cand_idx_r, 2'b00} +: 4] <= dec_s[3:0];
            blank_r[cand_idx_r] <= 1'b0;
            err_r[cand_idx_r]   <= 1'b0;
          end
          2'b01: begin
            blank_r[cand_idx_r] <= 1'b1;
            err_r[cand_idx_r]   <= 1'b0;
          end
          default: begin
            blank_r[cand_idx_r] <= 1'b0;
            err_r[cand_idx_r]   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign value   = value_r;
  assign blank   = blank_r;
  assign err     = err_r;
  assign upd     = upd_r;
  assign upd_idx = upd_idx_r;

endmodule

// File: tb/tb_seg7_bus_reader.sv
// Directed and random checks of seg7_bus_reader against a run-length reference model.
module tb_seg7_bus_reader;

  localparam int S = 4;
  localparam int L = (S < 2) ? 2 : S;  // identical samples needed before a commit

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  blank, err;
  logic        upd;
  logic [1:0]  upd_idx;

  int checks = 0;
  int errors = 0;
  int upd_count = 0;

  always #5 clk = ~clk;

  seg7_bus_reader #(.STABLE_CYCLES(S), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .dig_n(dig_n),
    .value(value), .blank(blank), .err(err), .upd(upd), .upd_idx(upd_idx)
  );

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [15:0] m_value;
  logic [3:0]  m_blank, m_err;
  logic        m_upd;
  logic [1:0]  m_idx;
  logic [10:0] run_key;
  int          run_len;
  logic        pa_v, pb_v;
  logic [1:0]  pa_i, pb_i;
  logic [6:0]  pa_p, pb_p;

  function automatic int sel_index(input logic [3:0] d);
    if ($countones(~d) != 1) return -1;
    for (int i = 0; i < 4; i++) if (d[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic apply(input logic [1:0] i, input logic [6:0] p);
    int n;
    n = -1;
    for (int j = 0; j < 16; j++) if (tbl[j] == p) n = j;
    m_idx = i;
    if (n >= 0) begin
      m_value[int'(i)*4 +: 4] = 4'(n);
      m_blank[i] = 1'b0;
      m_err[i]   = 1'b0;
    end else if (p == 7'h7F) begin
      m_blank[i] = 1'b1;
      m_err[i]   = 1'b0;
    end else begin
      m_blank[i] = 1'b0;
      m_err[i]   = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive pins, advance the model, then compare all outputs.
  task automatic step(input logic [3:0] d, input logic [6:0] s, input logic r);
    int k;
    logic ev_v;
    dig_n = d;
    seg_n = s;
    reset = r;
    if (r) begin
      m_value = 16'h0000; m_blank = 4'hF; m_err = 4'h0; m_upd = 1'b0; m_idx = 2'd0;
      run_len = 0; pa_v = 1'b0; pb_v = 1'b0;
    end else begin
      k = sel_index(d);
      ev_v = 1'b0;
      if (k < 0) run_len = 0;
      else if (run_len > 0 && run_key == {d, s}) run_len++;
      else begin run_key = {d, s}; run_len = 1; end
      if (k >= 0 && run_len == L) ev_v = 1'b1;
      m_upd = pb_v;
      if (pb_v) apply(pb_i, pb_p);
      pb_v = pa_v; pb_i = pa_i; pb_p = pa_p;
      pa_v = ev_v; pa_i = k[1:0]; pa_p = s;
    end
    @(posedge clk);
    #1;
    if (upd === 1'b1) upd_count++;
    check("upd", 32'(upd), 32'(m_upd));
    check("upd_idx", 32'(upd_idx), 32'(m_idx));
    check("value", 32'(value), 32'(m_value));
    check("blank", 32'(blank), 32'(m_blank));
    check("err", 32'(err), 32'(m_err));
  endtask

  logic [3:0]  dig_scan [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0]  seg_scan [4] = '{7'h0E, 7'h21, 7'h46, 7'h03};

  initial begin
    logic [10:0] prev;
    logic [3:0]  rd;
    logic [6:0]  rs;
    int          h;

    // Reset
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    check("rst_value", 32'(value), 32'h0000);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_err", 32'(err), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);

    // Single digit commit
    upd_count = 0;
    repeat (6) step(4'hE, 7'h30, 1'b0);
    check("t1_upds", upd_count, 1);
    check("t1_value", 32'(value), 32'h0003);
    check("t1_blank", 32'(blank), 32'hE);

    // Four-digit scan
    upd_count = 0;
    for (int j = 0; j < 4; j++) repeat (5) step(dig_scan[j], seg_scan[j], 1'b0);
    repeat (2) step(4'h7, 7'h03, 1'b0);
    check("scan_upds", upd_count, 4);
    check("scan_value", 32'(value), 32'hBCDF);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_err", 32'(err), 32'h0);

    // Glitch rejection
    upd_count = 0;
    repeat (3) step(4'hD, 7'h19, 1'b0);
    repeat (7) step(4'hD, 7'h12, 1'b0);
    check("glitch_upds", upd_count, 1);
    check("glitch_value", 32'(value), 32'hBC5F);

    // Illegal then blank on slot 2
    repeat (7) step(4'hB, 7'h55, 1'b0);
    check("illegal_err", 32'(err), 32'h4);
    check("illegal_value", 32'(value), 32'hBC5F);
    repeat (7) step(4'hB, 7'h7F, 1'b0);
    check("blank_blank", 32'(blank), 32'h4);
    check("blank_err", 32'(err), 32'h0);

    // Invalid selects, then one long hold
    upd_count = 0;
    repeat (10) step(4'hF, 7'($urandom), 1'b0);
    repeat (10) step(4'hC, 7'($urandom), 1'b0);
    check("invalid_upds", upd_count, 0);
    repeat (20) step(4'hD, 7'h12, 1'b0);
    check("hold_upds", upd_count, 1);

    // Reset lands on the commit cycle
    upd_count = 0;
    repeat (L + 1) step(4'h7, 7'h03, 1'b0);
    step(4'h7, 7'h03, 1'b1);
    check("rc_upd", 32'(upd), 32'h0);
    check("rc_value", 32'(value), 32'h0000);
    check("rc_blank", 32'(blank), 32'hF);
    step(4'h7, 7'h03, 1'b0);
    check("rc_next_value", 32'(value), 32'h0000);
    check("rc_upds", upd_count, 0);
    repeat (L + 2) step(4'h7, 7'h03, 1'b0);

    // Random holds; a hold of exactly L samples is avoided so a change never lands on the commit cycle
    prev = {4'h7, 7'h03};
    repeat (150) begin
      do begin
        if ($urandom_range(0, 7) == 0) begin
          do rd = 4'($urandom); while ($countones(~rd) == 1);
        end else begin
          rd = dig_scan[$urandom_range(0, 3)];
        end
        case ($urandom_range(0, 5))
          0:       rs = 7'h7F;
          1:       rs = 7'($urandom);
          default: rs = tbl[$urandom_range(0, 15)];
        endcase
      end while ({rd, rs} == prev);
      prev = {rd, rs};
      do h = $urandom_range(1, 7); while (h == L);
      repeat (h) step(rd, rs, 1'b0);
    end
    repeat (3) step(4'hF, 7'h7F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
